parity_tx_serializer: RTL and testbench

Transmit-side companion to the team's serial Mealy parity checker. Accepts parallel data words over a valid/ready handshake, shifts them out one bit per accepted beat (LSB first), then appends one parity bit so that a downstream checker reading the full frame ends in its "parity OK" state. Sits between a word-level producer and the single-bit serial link.

---
 rtl/parity_tx_serializer_pkg.sv | 6 +
 rtl/piso_shift_reg.sv | 18 +
 rtl/parity_tx_serializer.sv | 58 +++++
 tb/tb_parity_tx_serializer.sv | 89 ++++++++
 4 files changed

// File: rtl/parity_tx_serializer_pkg.sv
// parity_tx_serializer_pkg: FSM states and parity-mode constants shared by the parity serializer and checker
package parity_tx_serializer_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_e;
  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD  = 1'b1;
endpackage

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: W-bit parallel-load, LSB-first serial-out register (clk, rst, load_i, shift_i, data_i -> q0_o)
module piso_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] data_i,
  output logic         q0_o
);
  logic [W-1:0] sr_q, sr_d;
  always_comb sr_d = load_i ? data_i : shift_i ? {1'b0, sr_q[W-1:1]} : sr_q;
  always_ff @(posedge clk)
    if (rst) sr_q <= '0;
    else sr_q <= sr_d;
  assign q0_o = sr_q[0];
endmodule

// File: rtl/parity_tx_serializer.sv
// parity_tx_serializer: word in (in_valid/in_ready/in_data) -> LSB-first serial beats plus parity beat out (tx_valid/tx_ready/tx_bit/tx_last)
module parity_tx_serializer
  import parity_tx_serializer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter bit ODD    = PAR_EVEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_bit,
  output logic              tx_last
);
  localparam int CW = $clog2(DATA_W);
  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            acc_q, acc_d;
  logic            sr_bit, accept, beat, last_beat;
  assign in_ready  = !reset && (state_q == IDLE || (state_q == PARITY && tx_ready));
  assign accept    = in_valid && in_ready;
  assign beat      = state_q == DATA && tx_ready;
  assign last_beat = cnt_q == CW'(DATA_W - 1);
  piso_shift_reg #(.W(DATA_W)) u_sr (
    .clk     (clk),
    .rst     (reset),
    .load_i  (accept),
    .shift_i (beat),
    .data_i  (in_data),
    .q0_o    (sr_bit)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  always_comb begin
    state_d = state_q == IDLE ? (accept ? DATA : IDLE)
            : state_q == DATA ? ((tx_ready && last_beat) ? PARITY : DATA)
            : tx_ready ? (in_valid ? DATA : IDLE) : PARITY;
    // counter saturates on the final data beat so it never wraps inside a frame
    cnt_d   = accept ? '0 : (beat && !last_beat) ? cnt_q + 1'b1 : cnt_q;
    acc_d   = accept ? ODD : beat ? acc_q ^ sr_bit : acc_q;
  end
  always_comb begin
    tx_valid = state_q != IDLE;
    tx_last  = state_q == PARITY;
    tx_bit   = state_q == DATA ? sr_bit : state_q == PARITY ? acc_q : 1'b0;
  end
endmodule

// File: tb/tb_parity_tx_serializer.sv
// tb_parity_tx_serializer: frame-queue reference model and loopback parity check for even and odd serializers
module tb_parity_tx_serializer;
  logic       clk = 1'b0, reset = 1'b1, in_valid = 1'b0, tx_ready = 1'b0;
  logic [7:0] in_data = '0;
  logic       ir0, tv0, tb0, tl0, ir1, tv1, tb1, tl1;
  logic [1:0] q0[$], q1[$];
  logic       run0 = 1'b0, run1 = 1'b0;
  int         n_chk = 0, n_pass = 0, words = 0;
  always #5 clk = ~clk;
  parity_tx_serializer #(.DATA_W(8), .ODD(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(ir0),
    .tx_valid(tv0), .tx_ready(tx_ready), .tx_bit(tb0), .tx_last(tl0));
  parity_tx_serializer #(.DATA_W(8), .ODD(1'b1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(ir1),
    .tx_valid(tv1), .tx_ready(tx_ready), .tx_bit(tb1), .tx_last(tl1));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step(input logic rs, input logic v, input logic [7:0] d, input logic r);
    logic exp_ir, p;
    reset = rs; in_valid = v; in_data = d; tx_ready = r;
    #1;
    exp_ir = !rs && (q0.size() == 0 || (q0.size() == 1 && r));
    chk("in_ready0", ir0, exp_ir);
    chk("in_ready1", ir1, exp_ir);
    if (rs) begin
      run0 = 1'b0; run1 = 1'b0;
    end else if (r) begin
      if (tv0) begin
        p = run0 ^ tb0;
        if (tl0) begin chk("loop_even", p, 1'b0); run0 = 1'b0; end else run0 = p;
      end
      if (tv1) begin
        p = run1 ^ tb1;
        if (tl1) begin chk("loop_odd", p, 1'b1); run1 = 1'b0; end else run1 = p;
      end
    end
    @(posedge clk);
    if (rs) begin
      q0.delete(); q1.delete();
    end else begin
      if (r && q0.size() > 0) begin
        void'(q0.pop_front()); void'(q1.pop_front());
      end
      if (v && exp_ir) begin
        words++;
        for (int i = 0; i < 8; i++) begin
          q0.push_back({1'b0, d[i]}); q1.push_back({1'b0, d[i]});
        end
        p = ^d;
        q0.push_back({1'b1, p}); q1.push_back({1'b1, ~p});
      end
    end
    @(negedge clk);
    chk("tx_valid0", tv0, q0.size() > 0);
    chk("tx_valid1", tv1, q1.size() > 0);
    chk("tx_bit0",  tb0, q0.size() > 0 ? q0[0][0] : 1'b0);
    chk("tx_bit1",  tb1, q1.size() > 0 ? q1[0][0] : 1'b0);
    chk("tx_last0", tl0, q0.size() > 0 ? q0[0][1] : 1'b0);
    chk("tx_last1", tl1, q1.size() > 0 ? q1[0][1] : 1'b0);
  endtask
  task automatic send(input logic [7:0] d);
    step(1'b0, 1'b1, d, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
  endtask
  initial begin
    @(negedge clk);
    step(1'b1, 1'b1, 8'h3C, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    send(8'hA5);
    send(8'h07);
    step(1'b0, 1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h01, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b1, 8'h5A, 1'b1);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 8'h00, !(i inside {4, 5, 6, 11, 12, 13}));
    step(1'b0, 1'b1, 8'hC3, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b1, 8'h55, 1'b1);
    send(8'h80);
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0);
    chk("enough_words", words >= 200, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
